rx_byte_pack: RTL and testbench

Receive-side stage directly downstream of the descrambler. Consumes the descrambled serial bit stream with its symbol counter and parses the 24-bit SIGNAL field (symbol 3) for RATE/LENGTH. It then drops the 16 SERVICE bits and packs PSDU bits LSB-first into bytes, discarding tail and pad bits. Bytes leave through a small FIFO on an AXI-stream-style byte interface toward the MAC/Ethernet side, with `dout_last` marking the final PSDU byte.

---
 rtl/rx_byte_pack.sv | 229 ++++++++++++++++++++++
 tb/tb_rx_byte_pack.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_byte_pack.sv
// rx_byte_pack: parses the 24-bit SIGNAL field from the descrambled bit stream,
// skips the SERVICE bits, packs PSDU bits LSB-first into bytes and hands them
// out through a small show-ahead FIFO with a last-byte flag.
// Optional feature: define RX_BYTE_PACK_PARITY_CHK_EN to reject SIGNAL fields
// with bad even parity; otherwise only LENGTH==0 is rejected.
module rx_byte_pack #(
    parameter int SIG_BITS     = 24,
    parameter int SERVICE_BITS = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic        din_vld,
    output logic        din_rdy,
    input  logic [7:0]  din_symb_cnt,
    output logic [7:0]  dout,
    output logic        dout_vld,
    input  logic        dout_rdy,
    output logic        dout_last,
    output logic [3:0]  sig_rate,
    output logic [11:0] sig_len,
    output logic        sig_vld,
    output logic        sig_err
);
    localparam int SigCntW  = $clog2(SIG_BITS + 1);
    localparam int ServCntW = $clog2(SERVICE_BITS + 1);
    localparam int PtrW     = $clog2(FIFO_DEPTH);
    localparam int CntW     = PtrW + 1;
    localparam logic [SigCntW-1:0]  SigLast  = SigCntW'(SIG_BITS - 1);
    localparam logic [ServCntW-1:0] ServLast = ServCntW'(SERVICE_BITS - 1);
    localparam logic [CntW-1:0]     FifoFull = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SIG, SERV, DATA, DRAIN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SIG_BITS-1:0]   r_sig_sr;
    logic [SigCntW-1:0]    r_sig_cnt;
    logic [ServCntW-1:0]   r_serv_cnt;
    logic [7:0]            r_acc;
    logic [2:0]            r_bit_cnt;
    logic [11:0]           r_byte_cnt;
    logic [3:0]            r_sig_rate;
    logic [11:0]           r_sig_len;
    logic                  r_sig_vld;
    logic                  r_sig_err;
    logic [8:0]            r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic [CntW-1:0]       r_count;

    logic                  w_beat;
    logic                  w_is_sig;
    logic                  w_is_data;
    logic                  w_full;
    logic                  w_fifo_rd;
    logic                  w_fifo_wr;
    logic                  w_wr_last;
    logic [7:0]            w_wr_byte;
    logic                  w_sig_start;
    logic                  w_sig_done;
    logic                  w_sig_ok;
    logic                  w_parity_ok;
    logic [SIG_BITS-1:0]   w_sig_word;
    logic                  w_unused;

    assign w_full    = (r_count == FifoFull);
    assign din_rdy   = !w_full;
    assign w_beat    = din_vld && din_rdy;
    assign w_is_sig  = (din_symb_cnt == 8'd3);
    assign w_is_data = (din_symb_cnt > 8'd3);
    assign w_fifo_rd = (r_count != '0) && dout_rdy;

    // the complete SIGNAL word as it would look once the current bit is shifted in
    assign w_sig_word = {din, r_sig_sr[SIG_BITS-1:1]};
    assign w_wr_byte  = {din, r_acc[7:1]};
    assign w_wr_last  = ((r_byte_cnt + 12'd1) == r_sig_len);

`ifdef RX_BYTE_PACK_PARITY_CHK_EN
    assign w_parity_ok = ~(^w_sig_word[17:0]);
`else
    assign w_parity_ok = 1'b1;
`endif

    assign w_sig_ok = w_parity_ok && (w_sig_word[16:5] != 12'd0);
    assign w_unused = ^{r_sig_sr[0], w_sig_word[SIG_BITS-1:17], w_sig_word[4]};

    assign dout      = r_mem[r_rd_ptr][7:0];
    assign dout_vld  = (r_count != '0);
    assign dout_last = r_mem[r_rd_ptr][8] && dout_vld;
    assign sig_rate  = r_sig_rate;
    assign sig_len   = r_sig_len;
    assign sig_vld   = r_sig_vld;
    assign sig_err   = r_sig_err;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic; a symbol-3 beat mid-frame restarts SIGNAL parsing
    always_comb begin
        w_state_nxt = r_state;
        w_sig_start = 1'b0;
        w_sig_done  = 1'b0;
        w_fifo_wr   = 1'b0;
        if (w_beat) begin
            case (r_state)
                IDLE, DRAIN: begin
                    if (w_is_sig) begin
                        w_state_nxt = SIG;
                        w_sig_start = 1'b1;
                    end
                end
                SIG: begin
                    if (r_sig_cnt == SigLast) begin
                        w_sig_done  = 1'b1;
                        w_state_nxt = w_sig_ok ? SERV : DRAIN;
                    end
                end
                SERV: begin
                    if (w_is_sig && (r_serv_cnt != '0)) begin
                        w_state_nxt = SIG;
                        w_sig_start = 1'b1;
                    end else if (w_is_data && (r_serv_cnt == ServLast)) begin
                        w_state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (w_is_sig) begin
                        w_state_nxt = SIG;
                        w_sig_start = 1'b1;
                    end else if (r_bit_cnt == 3'd7) begin
                        w_fifo_wr = 1'b1;
                        if (w_wr_last) begin
                            w_state_nxt = DRAIN;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // SIGNAL shifting, field latching, SERVICE skipping and byte packing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig_sr   <= '0;
            r_sig_cnt  <= '0;
            r_serv_cnt <= '0;
            r_acc      <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_sig_rate <= '0;
            r_sig_len  <= '0;
            r_sig_vld  <= 1'b0;
            r_sig_err  <= 1'b0;
        end else begin
            r_sig_vld <= 1'b0;
            r_sig_err <= 1'b0;
            if (w_sig_start) begin
                r_sig_sr   <= w_sig_word;
                r_sig_cnt  <= SigCntW'(1);
                r_serv_cnt <= '0;
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
            end else if (w_beat) begin
                case (r_state)
                    SIG: begin
                        r_sig_sr  <= w_sig_word;
                        r_sig_cnt <= r_sig_cnt + SigCntW'(1);
                        if (w_sig_done) begin
                            if (w_sig_ok) begin
                                r_sig_rate <= w_sig_word[3:0];
                                r_sig_len  <= w_sig_word[16:5];
                                r_sig_vld  <= 1'b1;
                            end else begin
                                r_sig_err  <= 1'b1;
                            end
                        end
                    end
                    SERV: begin
                        if (w_is_data) begin
                            r_serv_cnt <= r_serv_cnt + ServCntW'(1);
                        end
                    end
                    DATA: begin
                        r_acc     <= w_wr_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_fifo_wr) begin
                            r_byte_cnt <= r_byte_cnt + 12'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // show-ahead output FIFO; writes never collide with full because din_rdy gates them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_fifo_wr) begin
                r_mem[r_wr_ptr] <= {w_wr_last, w_wr_byte};
                r_wr_ptr        <= r_wr_ptr + PtrW'(1);
            end
            if (w_fifo_rd) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            case ({w_fifo_wr, w_fifo_rd})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_byte_pack.sv
// tb_rx_byte_pack: directed frames against a queue-based model of rx_byte_pack.
// The model builds SIGNAL words and expected bytes straight from the field map;
// a monitor compares every popped byte and every sig_vld pulse against it.
module tb_rx_byte_pack;
    logic        clk;
    logic        rst;
    logic        din;
    logic        din_vld;
    logic        din_rdy;
    logic [7:0]  din_symb_cnt;
    logic [7:0]  dout;
    logic        dout_vld;
    logic        dout_rdy;
    logic        dout_last;
    logic [3:0]  sig_rate;
    logic [11:0] sig_len;
    logic        sig_vld;
    logic        sig_err;

`ifdef RX_BYTE_PACK_PARITY_CHK_EN
    localparam bit ParityChk = 1'b1;
`else
    localparam bit ParityChk = 1'b0;
`endif

    int testsRun = 0;
    int testsFailed = 0;
    int popCount = 0;
    int lastSeen = 0;
    int sigVldSeen = 0;
    int sigErrSeen = 0;
    int bitsSent = 0;
    logic [8:0] lastPopped = '0;
    logic [8:0] expQ[$];
    logic [3:0] expRate = '0;
    logic [11:0] expLen = '0;
    bit dataBits[0:1023];

    rx_byte_pack #(.SIG_BITS(24), .SERVICE_BITS(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
        .din_symb_cnt(din_symb_cnt), .dout(dout), .dout_vld(dout_vld),
        .dout_rdy(dout_rdy), .dout_last(dout_last), .sig_rate(sig_rate),
        .sig_len(sig_len), .sig_vld(sig_vld), .sig_err(sig_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SIGNAL word from the field map: RATE, reserved 0, LENGTH, even parity, zero tail
    function automatic logic [23:0] makeSignal(input logic [3:0] rate, input logic [11:0] len, input bit flipPar);
        logic [23:0] w;
        w = '0;
        w[3:0] = rate;
        w[16:5] = len;
        w[17] = (^w[16:0]) ^ flipPar;
        return w;
    endfunction

    task automatic sendBit(input bit b, input logic [7:0] symb);
        int guard;
        guard = 0;
        din = b;
        din_symb_cnt = symb;
        din_vld = 1'b1;
        while (!din_rdy && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL din_rdy timeout: din_rdy=%0b, expected 1", din_rdy);
        end
        @(negedge clk);
        bitsSent++;
    endtask

    // one frame: 24 SIGNAL bits, 16 SERVICE bits, nData bits from dataBits
    task automatic applyStimulus(input logic [3:0] rate, input logic [11:0] len, input bit flipPar, input int nData);
        logic [23:0] sw;
        logic [7:0] packed8;
        bit accept;
        int nBytes;
        sw = makeSignal(rate, len, flipPar);
        accept = (len != 12'd0) && (!ParityChk || (^sw[17:0]) == 1'b0);
        if (accept) begin
            expRate = rate;
            expLen = len;
            nBytes = nData / 8;
            if (nBytes > int'(len)) nBytes = int'(len);
            for (int k = 0; k < nBytes; k++) begin
                packed8 = '0;
                for (int i = 0; i < 8; i++) packed8[i] = dataBits[8*k + i];
                expQ.push_back({(k == int'(len) - 1), packed8});
            end
        end
        for (int i = 0; i < 24; i++) sendBit(sw[i], 8'd3);
        for (int i = 0; i < 16; i++) sendBit(i[0], 8'd4);
        for (int i = 0; i < nData; i++) sendBit(dataBits[i], 8'd5);
    endtask

    task automatic fillData(input int seed);
        for (int i = 0; i < 1024; i++) dataBits[i] = (((i * 37 + seed) % 7) < 3);
    endtask

    task automatic idleCycles(input int n);
        din_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " din_rdy"}, din_rdy, 1);
        checkOutput({tag, " dout"}, dout, 0);
        checkOutput({tag, " dout_vld"}, dout_vld, 0);
        checkOutput({tag, " dout_last"}, dout_last, 0);
        checkOutput({tag, " sig_rate"}, sig_rate, 0);
        checkOutput({tag, " sig_len"}, sig_len, 0);
        checkOutput({tag, " sig_vld"}, sig_vld, 0);
        checkOutput({tag, " sig_err"}, sig_err, 0);
    endtask

    // monitor: sample mid-cycle, pop the model on every handshake, check SIGNAL pulses
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (dout_vld && dout_rdy) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected byte: got 0x%0h last=%0b, expected no output", dout, dout_last);
                end else begin
                    checkOutput("byte", {dout_last, dout}, expQ.pop_front());
                end
                lastPopped = {dout_last, dout};
                popCount++;
                if (dout_last) lastSeen++;
            end
            if (sig_vld) begin
                sigVldSeen++;
                checkOutput("sig_rate at sig_vld", sig_rate, expRate);
                checkOutput("sig_len at sig_vld", sig_len, expLen);
            end
            if (sig_err) sigErrSeen++;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int basePop, baseLast, baseVld, baseErr, baseBits;
        int expErr, expVld, expPop;
        rst = 1'b1;
        din = 1'b0;
        din_vld = 1'b0;
        din_symb_cnt = 8'd0;
        dout_rdy = 1'b1;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        @(negedge clk);

        // hand-computed SIGNAL words pin the model
        checkOutput("model signal rate11 len100", makeSignal(4'd11, 12'd100, 1'b0), 32'h000C8B);
        checkOutput("model signal rate11 len1", makeSignal(4'd11, 12'd1, 1'b0), 32'h00002B);

        // frame A: 800 data + 6 tail + 10 pad
        fillData(11);
        basePop = popCount; baseLast = lastSeen; baseVld = sigVldSeen;
        applyStimulus(4'd11, 12'd100, 1'b0, 816);
        idleCycles(20);
        checkOutput("A sig_vld count", sigVldSeen - baseVld, 1);
        checkOutput("A sig_rate", sig_rate, 11);
        checkOutput("A sig_len", sig_len, 100);
        checkOutput("A bytes", popCount - basePop, 100);
        checkOutput("A last count", lastSeen - baseLast, 1);
        checkOutput("A queue drained", expQ.size(), 0);

        // frame B: same frame, parity bit flipped
        basePop = popCount; baseVld = sigVldSeen; baseErr = sigErrSeen;
        expErr = ParityChk ? 1 : 0;
        expVld = ParityChk ? 0 : 1;
        expPop = ParityChk ? 0 : 100;
        applyStimulus(4'd11, 12'd100, 1'b1, 816);
        idleCycles(20);
        checkOutput("B sig_err count", sigErrSeen - baseErr, expErr);
        checkOutput("B sig_vld count", sigVldSeen - baseVld, expVld);
        checkOutput("B bytes", popCount - basePop, expPop);
        checkOutput("B sig_len", sig_len, 100);
        checkOutput("B queue drained", expQ.size(), 0);

        // LENGTH=0 is rejected in every build and leaves the held fields alone
        baseErr = sigErrSeen; basePop = popCount;
        applyStimulus(4'd6, 12'd0, 1'b0, 16);
        idleCycles(10);
        checkOutput("L0 sig_err count", sigErrSeen - baseErr, 1);
        checkOutput("L0 bytes", popCount - basePop, 0);
        checkOutput("L0 sig_len held", sig_len, 100);
        checkOutput("L0 sig_rate held", sig_rate, 11);

        // LENGTH=1 with bits 1,0,1,0,0,0,0,0 then pad of ones
        for (int i = 0; i < 16; i++) dataBits[i] = (i >= 8) || (i == 0) || (i == 2);
        basePop = popCount;
        applyStimulus(4'd11, 12'd1, 1'b0, 16);
        idleCycles(10);
        checkOutput("L1 bytes", popCount - basePop, 1);
        checkOutput("L1 byte with last", lastPopped, 9'h105);
        checkOutput("L1 sig_len", sig_len, 1);

        // backpressure: FIFO fills after 4 bytes, din_rdy drops, then drains in order
        fillData(3);
        dout_rdy = 1'b0;
        basePop = popCount;
        baseBits = bitsSent;
        fork
            begin
                applyStimulus(4'd13, 12'd6, 1'b0, 48);
            end
            begin
                int waitCnt;
                waitCnt = 0;
                @(negedge clk);
                #1;
                while (din_rdy && waitCnt < 500) begin
                    @(negedge clk);
                    #1;
                    waitCnt++;
                end
                checkOutput("BP din_rdy dropped", din_rdy, 0);
                checkOutput("BP bits at stall", bitsSent - baseBits, 72);
                repeat (10) @(negedge clk);
                #1;
                checkOutput("BP still stalled", bitsSent - baseBits, 72);
                checkOutput("BP fifo full dout_vld", dout_vld, 1);
                dout_rdy = 1'b1;
            end
        join
        idleCycles(20);
        checkOutput("BP bytes", popCount - basePop, 6);
        checkOutput("BP queue drained", expQ.size(), 0);

        // abort after 3.5 data bytes, then a fresh frame right behind it
        fillData(5);
        basePop = popCount; baseLast = lastSeen; baseVld = sigVldSeen;
        applyStimulus(4'd9, 12'd10, 1'b0, 28);
        fillData(1);
        applyStimulus(4'd15, 12'd3, 1'b0, 32);
        idleCycles(20);
        checkOutput("AB bytes", popCount - basePop, 6);
        checkOutput("AB last count", lastSeen - baseLast, 1);
        checkOutput("AB sig_vld count", sigVldSeen - baseVld, 2);
        checkOutput("AB sig_len", sig_len, 3);
        checkOutput("AB queue drained", expQ.size(), 0);

        // asynchronous reset mid-DATA with 2 bytes queued
        fillData(2);
        dout_rdy = 1'b0;
        applyStimulus(4'd7, 12'd10, 1'b0, 20);
        checkOutput("RS bytes queued", dout_vld, 1);
        rst = 1'b1;
        din_vld = 1'b0;
        expQ.delete();
        #1;
        checkResetValues("mid-frame reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dout_rdy = 1'b1;
        @(negedge clk);
        fillData(9);
        basePop = popCount; baseLast = lastSeen;
        applyStimulus(4'd5, 12'd4, 1'b0, 40);
        idleCycles(20);
        checkOutput("RS next frame bytes", popCount - basePop, 4);
        checkOutput("RS next frame last", lastSeen - baseLast, 1);
        checkOutput("RS sig_rate", sig_rate, 5);
        checkOutput("RS sig_len", sig_len, 4);
        checkOutput("RS queue drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
